// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared owner tags and write-enable constants for the memory arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_INST = 2'd1,
    OWN_DATA = 2'd2
  } owner_t;

  localparam logic [3:0] WEA_NONE = 4'b0000;
  localparam logic [3:0] WEA_WORD = 4'b1111;

endpackage

// File: rtl/mem_arb_resp_pipe.sv
// rtl/mem_arb_resp_pipe.sv - owner-tag delay line that says which port a RAM read beat belongs to
module mem_arb_resp_pipe
  import mem_arb_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic   clk,
  input  logic   clr_i,
  input  owner_t tag_i,
  output owner_t tag_o
);

  owner_t pipe_q [DEPTH];

  // Shift the issuing owner down the line; a clear drops every read still in flight
  always_ff @(posedge clk) begin
    if (clr_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        pipe_q[i] <= OWN_NONE;
      end
    end else begin
      pipe_q[0] <= tag_i;
      for (int i = 1; i < DEPTH; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign tag_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port RAM arbiter, data port over inst port; MEM_ARB_STARVE_GUARD_EN adds an inst starvation guard
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_SHIFT = 2,
  parameter int RD_LATENCY = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic [3:0]  d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        m_ena,
  output logic [3:0]  m_wea,
  output logic [31:0] m_addra,
  output logic [31:0] m_dina,
  input  logic [31:0] m_douta
);

  logic        force_inst;
  owner_t      tag_d;
  owner_t      tag_due;
  logic [31:0] i_rdata_q;
  logic [31:0] d_rdata_q;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [SW-1:0] starve_q;
  logic [SW-1:0] starve_d;

  assign force_inst = (starve_q == SW'(STARVE_MAX));

  // Count back-to-back inst denials; a grant or a withdrawn request restarts the run
  always_comb begin
    starve_d = '0;
    if (i_req && !i_gnt) begin
      starve_d = starve_q + SW'(1);
    end
  end

  // Denial counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  logic unused_starve_cfg;

  assign force_inst        = 1'b0;
  assign unused_starve_cfg = (STARVE_MAX != 0);
`endif

  // Pick one requester per cycle and steer its request onto the RAM port
  always_comb begin
    i_gnt   = 1'b0;
    d_gnt   = 1'b0;
    m_ena   = 1'b0;
    m_wea   = WEA_NONE;
    m_addra = '0;
    m_dina  = '0;
    tag_d   = OWN_NONE;
    if (!rst) begin
      if (i_req && (force_inst || !d_req)) begin
        i_gnt   = 1'b1;
        m_ena   = 1'b1;
        m_addra = i_addr >> ADDR_SHIFT;
        tag_d   = OWN_INST;
      end else if (d_req) begin
        d_gnt   = 1'b1;
        m_ena   = 1'b1;
        m_addra = d_addr >> ADDR_SHIFT;
        m_wea   = d_we & WEA_WORD;
        m_dina  = d_wdata;
        if (d_we == WEA_NONE) begin
          tag_d = OWN_DATA;
        end
      end
    end
  end

  mem_arb_resp_pipe #(
    .DEPTH (RD_LATENCY)
  ) u_resp_pipe (
    .clk   (clk),
    .clr_i (rst),
    .tag_i (tag_d),
    .tag_o (tag_due)
  );

  assign i_rvalid = !rst && (tag_due == OWN_INST);
  assign d_rvalid = !rst && (tag_due == OWN_DATA);

  // Keep the last delivered word of each port visible between responses
  always_ff @(posedge clk) begin
    if (rst) begin
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      if (i_rvalid) begin
        i_rdata_q <= m_douta;
      end
      if (d_rvalid) begin
        d_rdata_q <= m_douta;
      end
    end
  end

  assign i_rdata = rst ? '0 : (i_rvalid ? m_douta : i_rdata_q);
  assign d_rdata = rst ? '0 : (d_rvalid ? m_douta : d_rdata_q);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed bench with a queue-based reference model for mem_arbiter
module tb_mem_arbiter;

  localparam int LAT    = 1;
  localparam int STARVE = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt;
  logic        i_rvalid;
  logic [31:0] i_rdata;
  logic        d_req;
  logic [3:0]  d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        m_ena;
  logic [3:0]  m_wea;
  logic [31:0] m_addra;
  logic [31:0] m_dina;
  logic [31:0] m_douta;

  always #5 clk = ~clk;

  mem_arbiter #(
    .ADDR_SHIFT (2),
    .RD_LATENCY (LAT),
    .STARVE_MAX (STARVE)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .i_req    (i_req),
    .i_addr   (i_addr),
    .i_gnt    (i_gnt),
    .i_rvalid (i_rvalid),
    .i_rdata  (i_rdata),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_gnt    (d_gnt),
    .d_rvalid (d_rvalid),
    .d_rdata  (d_rdata),
    .m_ena    (m_ena),
    .m_wea    (m_wea),
    .m_addra  (m_addra),
    .m_dina   (m_dina),
    .m_douta  (m_douta)
  );

  // Block RAM: one-cycle read latency, byte write enables
  logic [31:0] ram [0:255];
  initial for (int k = 0; k < 256; k++) ram[k] = 32'h0;

  always @(posedge clk) begin
    if (m_ena) begin
      for (int b = 0; b < 4; b++) begin
        if (m_wea[b]) ram[m_addra[7:0]][8*b +: 8] <= m_dina[8*b +: 8];
      end
      m_douta <= ram[m_addra[7:0]];
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: expected reads are queued with the cycle they must appear in
  typedef struct {
    int          port;
    logic [31:0] data;
    int          due;
  } resp_t;

  resp_t       pend[$];
  logic [31:0] shadow [0:255];
  logic [31:0] hold_i = 32'h0;
  logic [31:0] hold_d = 32'h0;
  int          deny = 0;
  int          cyc = 0;

  initial for (int k = 0; k < 256; k++) shadow[k] = 32'h0;

  always @(negedge clk) begin
    logic        eg_i, eg_d, ev_i, ev_d, frc;
    logic [31:0] ea, edin;
    logic [3:0]  ewe;
    resp_t       r;
    eg_i = 1'b0;
    eg_d = 1'b0;
    ev_i = 1'b0;
    ev_d = 1'b0;
`ifdef MEM_ARB_STARVE_GUARD_EN
    frc = (deny >= STARVE);
`else
    frc = 1'b0;
`endif
    if (!rst) begin
      if (i_req && (frc || !d_req)) eg_i = 1'b1;
      else if (d_req)               eg_d = 1'b1;
    end
    ea   = eg_i ? (i_addr / 4) : (eg_d ? (d_addr / 4) : 32'h0);
    ewe  = eg_d ? d_we : 4'h0;
    edin = eg_d ? d_wdata : 32'h0;
    if (!rst && pend.size() > 0 && pend[0].due == cyc) begin
      if (pend[0].port == 0) begin
        ev_i   = 1'b1;
        hold_i = pend[0].data;
      end else begin
        ev_d   = 1'b1;
        hold_d = pend[0].data;
      end
      void'(pend.pop_front());
    end
    chk("i_gnt",    i_gnt,    eg_i);
    chk("d_gnt",    d_gnt,    eg_d);
    chk("m_ena",    m_ena,    eg_i | eg_d);
    chk("m_addra",  m_addra,  ea);
    chk("m_wea",    m_wea,    ewe);
    chk("m_dina",   m_dina,   edin);
    chk("i_rvalid", i_rvalid, ev_i);
    chk("d_rvalid", d_rvalid, ev_d);
    chk("i_rdata",  i_rdata,  rst ? 32'h0 : hold_i);
    chk("d_rdata",  d_rdata,  rst ? 32'h0 : hold_d);
    if (rst) begin
      pend.delete();
      hold_i = 32'h0;
      hold_d = 32'h0;
      deny   = 0;
    end else begin
      if (eg_i) begin
        r.port = 0;
        r.data = shadow[ea[7:0]];
        r.due  = cyc + LAT;
        pend.push_back(r);
      end
      if (eg_d) begin
        if (d_we == 4'h0) begin
          r.port = 1;
          r.data = shadow[ea[7:0]];
          r.due  = cyc + LAT;
          pend.push_back(r);
        end else begin
          for (int b = 0; b < 4; b++) begin
            if (d_we[b]) shadow[ea[7:0]][8*b +: 8] = d_wdata[8*b +: 8];
          end
        end
      end
      deny = (i_req && !eg_i) ? deny + 1 : 0;
    end
    cyc++;
  end

  // Apply one cycle of inputs just after the edge, return at the following negedge
  task automatic step(input logic r, input logic ir, input logic [31:0] ia,
                      input logic dr, input logic [3:0] dw, input logic [31:0] da,
                      input logic [31:0] dd);
    @(posedge clk);
    #1;
    rst     = r;
    i_req   = ir;
    i_addr  = ia;
    d_req   = dr;
    d_we    = dw;
    d_addr  = da;
    d_wdata = dd;
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int n;
    int exp_n;
    rst = 1'b1; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = '0; d_addr = '0; d_wdata = '0;
    step(1'b1, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    step(1'b1, 1'b1, 32'h0, 1'b1, 4'h0, 32'h4, 32'h0);
    chk("rst_no_gnt",   {i_gnt, d_gnt, m_ena}, 32'h0);
    chk("rst_i_rdata",  i_rdata, 32'h0);

    // Write then read back the same word
    step(1'b0, 1'b0, 32'h0, 1'b1, 4'hF, 32'h4, 32'h0000_1234);
    chk("wr_d_gnt", d_gnt, 1'b1);
    chk("wr_addra", m_addra, 32'h1);
    chk("wr_wea",   m_wea, 4'hF);
    step(1'b0, 1'b0, 32'h0, 1'b1, 4'h0, 32'h4, 32'h0);
    chk("rd_d_gnt", d_gnt, 1'b1);
    chk("rd_addra", m_addra, 32'h1);
    chk("rd_early_rvalid", d_rvalid, 1'b0);
    idle();
    chk("rd_rvalid", d_rvalid, 1'b1);
    chk("rd_rdata",  d_rdata, 32'h0000_1234);
    idle();
    chk("rd_rvalid_once", d_rvalid, 1'b0);
    chk("rd_rdata_held",  d_rdata, 32'h0000_1234);

    // Conflict: data wins, inst served next cycle, responses routed in order
    step(1'b0, 1'b0, 32'h0, 1'b1, 4'hF, 32'h8, 32'hCAFE_0002);
    step(1'b0, 1'b1, 32'h8, 1'b1, 4'h0, 32'h4, 32'h0);
    chk("cf_d_gnt", d_gnt, 1'b1);
    chk("cf_i_gnt", i_gnt, 1'b0);
    step(1'b0, 1'b1, 32'h8, 1'b0, 4'h0, 32'h0, 32'h0);
    chk("cf_i_gnt2",   i_gnt, 1'b1);
    chk("cf_addra2",   m_addra, 32'h2);
    chk("cf_d_rvalid", d_rvalid, 1'b1);
    chk("cf_d_rdata",  d_rdata, 32'h0000_1234);
    idle();
    chk("cf_i_rvalid", i_rvalid, 1'b1);
    chk("cf_i_rdata",  i_rdata, 32'hCAFE_0002);
    chk("cf_d_quiet",  d_rvalid, 1'b0);

    // Byte-lane write merges into the existing word
    step(1'b0, 1'b0, 32'h0, 1'b1, 4'hF, 32'h4, 32'hFFFF_FFFF);
    step(1'b0, 1'b0, 32'h0, 1'b1, 4'h3, 32'h4, 32'h0000_ABCD);
    chk("bw_wea", m_wea, 4'h3);
    step(1'b0, 1'b0, 32'h0, 1'b1, 4'h0, 32'h4, 32'h0);
    idle();
    chk("bw_rvalid", d_rvalid, 1'b1);
    chk("bw_rdata",  d_rdata, 32'hFFFF_ABCD);

    // Reset while an inst read is in flight
    step(1'b0, 1'b1, 32'h8, 1'b0, 4'h0, 32'h0, 32'h0);
    chk("rs_i_gnt", i_gnt, 1'b1);
    step(1'b1, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    chk("rs_i_rvalid", i_rvalid, 1'b0);
    chk("rs_m_ena",    m_ena, 1'b0);
    chk("rs_rdata",    i_rdata | d_rdata, 32'h0);
    idle();
    chk("rs_after_rvalid", i_rvalid, 1'b0);
    chk("rs_after_d_rdata", d_rdata, 32'h0);
    step(1'b0, 1'b1, 32'h8, 1'b0, 4'h0, 32'h0, 32'h0);
    chk("rs_fresh_gnt", i_gnt, 1'b1);
    idle();
    chk("rs_fresh_rvalid", i_rvalid, 1'b1);
    chk("rs_fresh_rdata",  i_rdata, 32'hCAFE_0002);

    // Both ports hammering for ten cycles
    n = 0;
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 1'b1, 32'h8, 1'b1, 4'h0, 32'h4, 32'h0);
      if (i_gnt) n++;
    end
`ifdef MEM_ARB_STARVE_GUARD_EN
    exp_n = 2;
`else
    exp_n = 0;
`endif
    chk("starve_inst_grants", n, exp_n);
    idle();
    idle();

    // Streaming inst reads
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 1'b0, 32'h0, 1'b1, 4'hF, 32'(k * 4), 32'hA000_0000 + 32'(k));
    end
    for (int k = 0; k <= 8; k++) begin
      step(1'b0, k < 8, 32'(k * 4), 1'b0, 4'h0, 32'h0, 32'h0);
      if (k > 0) begin
        chk("st_rvalid", i_rvalid, 1'b1);
        chk("st_rdata",  i_rdata, 32'hA000_0000 + 32'(k - 1));
      end
    end
    idle();
    chk("st_done", i_rvalid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
